// File: rtl/pulse_spacer.sv
// Queues single-cycle event pulses and re-emits them at least pGAP_CYCLES apart,
// so the downstream req/ack pulse synchronizer never loses an event.
module pulse_spacer #(
    parameter int pCNT_WIDTH  = 4,
    parameter int pGAP_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  in_pulse,
    output logic                  out_pulse,
    output logic [pCNT_WIDTH-1:0] pending,
    output logic                  overflow,
    output logic                  idle
);

    localparam int GAP_W = (pGAP_CYCLES > 2) ? $clog2(pGAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]      GAP_LOAD = GAP_W'(pGAP_CYCLES - 2);
    localparam logic [GAP_W-1:0]      GAP_ONE  = GAP_W'(1);
    localparam logic [pCNT_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [pCNT_WIDTH-1:0] PEND_ONE = pCNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_next;
    logic             dec;
    logic             inc;

    // A fire consumes one queued event, which frees a slot for a same-cycle arrival.
    always_comb begin
        state_next   = state;
        gap_cnt_next = gap_cnt;
        case (state)
            IDLE: begin
                if (in_pulse || (pending != '0)) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                state_next   = GAP;
                gap_cnt_next = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = (in_pulse || (pending != '0)) ? FIRE : IDLE;
                end else begin
                    gap_cnt_next = gap_cnt - GAP_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
        dec = (state_next == FIRE);
        inc = in_pulse & ((pending != PEND_MAX) | dec);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            out_pulse <= 1'b0;
        end else if (clr_i) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            out_pulse <= 1'b0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_cnt_next;
            out_pulse <= (state_next == FIRE);
            if (inc && !dec) begin
                pending <= pending + PEND_ONE;
            end else if (dec && !inc) begin
                pending <= pending - PEND_ONE;
            end
            if (in_pulse && !inc) begin
                overflow <= 1'b1;
            end
        end
    end

    assign idle = (state == IDLE) && (pending == '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// Self-checking bench for pulse_spacer: directed scenarios plus randomized traffic
// checked against an event-queue model (backlog count plus time of last emitted pulse).
module tb_pulse_spacer;

    localparam int CW   = 2;
    localparam int GAP  = 4;
    localparam int MAXP = 3;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b1;
    logic          clr_i    = 1'b0;
    logic          in_pulse = 1'b0;
    logic          out_pulse;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: backlog count, sticky drop flag, cycle of the last emitted pulse.
    int   m_t    = 0;
    int   m_last = -1000;
    int   m_pend = 0;
    logic m_ovf  = 1'b0;
    logic m_out  = 1'b0;

    always #5 clk = ~clk;

    pulse_spacer #(
        .pCNT_WIDTH (CW),
        .pGAP_CYCLES(GAP)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (clr_i),
        .in_pulse (in_pulse),
        .out_pulse(out_pulse),
        .pending  (pending),
        .overflow (overflow),
        .idle     (idle)
    );

    task automatic model_clear();
        m_pend = 0;
        m_ovf  = 1'b0;
        m_out  = 1'b0;
        m_last = -1000;
    endtask

    // A pulse goes out whenever work exists and the last pulse is at least GAP cycles old.
    task automatic model_step(input logic inp, input logic clr);
        if (clr) begin
            model_clear();
        end else if (((m_pend > 0) || inp) && ((m_t + 1 - m_last) >= GAP)) begin
            m_out  = 1'b1;
            m_last = m_t + 1;
            m_pend = m_pend + int'(inp) - 1;
        end else begin
            m_out = 1'b0;
            if (inp) begin
                if (m_pend < MAXP) m_pend++;
                else m_ovf = 1'b1;
            end
        end
        m_t++;
    endtask

    function automatic logic model_idle();
        return !m_out && ((m_t - m_last) >= GAP) && (m_pend == 0);
    endfunction

    task automatic tick(input logic inp, input logic clr);
        in_pulse = inp;
        clr_i    = clr;
        @(posedge clk);
        model_step(inp, clr);
        @(negedge clk);
        in_pulse = 1'b0;
        clr_i    = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (out_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out: got %b want 0", out_pulse); end
        n_checks++; if (pending !== '0) begin n_fail++; $display("[TB] FAIL rst_pending: got %0d want 0", pending); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_overflow: got %b want 0", overflow); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_idle: got %b want 1", idle); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick(c == 0, 1'b0);
            n_checks++; if (out_pulse !== (c + 1 == 1)) begin n_fail++; $display("[TB] FAIL single_out cyc %0d: got %b want %b", c + 1, out_pulse, (c + 1 == 1)); end
            n_checks++; if (pending !== '0) begin n_fail++; $display("[TB] FAIL single_pending cyc %0d: got %0d want 0", c + 1, pending); end
            n_checks++; if (idle !== (c + 1 >= 5)) begin n_fail++; $display("[TB] FAIL single_idle cyc %0d: got %b want %b", c + 1, idle, (c + 1 >= 5)); end
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        tick(1'b0, 1'b1);
        for (int c = 0; c < 23; c++) begin
            int cyc;
            logic exp_out;
            tick(c <= 5, 1'b0);
            cyc     = c + 1;
            exp_out = (cyc inside {1, 5, 9, 13, 17});
            if (int'(pending) > peak) peak = int'(pending);
            n_checks++; if (out_pulse !== exp_out) begin n_fail++; $display("[TB] FAIL burst_out cyc %0d: got %b want %b", cyc, out_pulse, exp_out); end
            n_checks++; if (overflow !== (cyc >= 6)) begin n_fail++; $display("[TB] FAIL burst_overflow cyc %0d: got %b want %b", cyc, overflow, (cyc >= 6)); end
            n_checks++; if (pending !== CW'(m_pend)) begin n_fail++; $display("[TB] FAIL burst_pending cyc %0d: got %0d want %0d", cyc, pending, m_pend); end
        end
        n_checks++; if (peak !== MAXP) begin n_fail++; $display("[TB] FAIL burst_peak: got %0d want %0d", peak, MAXP); end
    endtask

    task automatic test_saturate();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 4; c++) tick(1'b1, 1'b0);
        n_checks++; if (pending !== CW'(MAXP)) begin n_fail++; $display("[TB] FAIL sat_pre_pending: got %0d want %0d", pending, MAXP); end
        tick(1'b1, 1'b0);
        n_checks++; if (pending !== CW'(MAXP)) begin n_fail++; $display("[TB] FAIL sat_pending: got %0d want %0d", pending, MAXP); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_overflow: got %b want 0", overflow); end
        n_checks++; if (out_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_out: got %b want 1", out_pulse); end
    endtask

    task automatic test_clear();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 18; c++) begin
            tick(c <= 5, c == 7);
            if (c + 1 >= 6) begin
                n_checks++; if (out_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_out cyc %0d: got %b want 0", c + 1, out_pulse); end
            end
            if (c + 1 == 8) begin
                n_checks++; if (pending !== '0) begin n_fail++; $display("[TB] FAIL clr_pending: got %0d want 0", pending); end
                n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_overflow: got %b want 0", overflow); end
                n_checks++; if (idle !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_idle: got %b want 1", idle); end
            end
        end
    endtask

    task automatic test_async_reset();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
        n_checks++; if (pending !== CW'(2)) begin n_fail++; $display("[TB] FAIL arst_pre_pending: got %0d want 2", pending); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (out_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_out: got %b want 0", out_pulse); end
        n_checks++; if (pending !== '0) begin n_fail++; $display("[TB] FAIL arst_pending: got %0d want 0", pending); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_overflow: got %b want 0", overflow); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        for (int c = 0; c < 12; c++) begin
            tick(1'b0, 1'b0);
            n_checks++; if (out_pulse !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_quiet cyc %0d: got %b want 0", c, out_pulse); end
        end
        tick(1'b1, 1'b0);
        n_checks++; if (out_pulse !== 1'b1) begin n_fail++; $display("[TB] FAIL arst_resume: got %b want 1", out_pulse); end
    endtask

    task automatic test_spacing();
        tick(1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            tick((c == 0) || (c == 2), 1'b0);
            n_checks++; if (out_pulse !== ((c + 1 == 1) || (c + 1 == 5))) begin n_fail++; $display("[TB] FAIL spacing_out cyc %0d: got %b want %b", c + 1, out_pulse, ((c + 1 == 1) || (c + 1 == 5))); end
        end
    endtask

    task automatic test_random();
        int density[3] = '{85, 35, 100};
        tick(1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 120; c++) begin
                tick($urandom_range(0, 99) < density[p], $urandom_range(0, 99) < 2);
                n_checks++; if (out_pulse !== m_out) begin n_fail++; $display("[TB] FAIL rand_out t %0d: got %b want %b", m_t, out_pulse, m_out); end
                n_checks++; if (pending !== CW'(m_pend)) begin n_fail++; $display("[TB] FAIL rand_pending t %0d: got %0d want %0d", m_t, pending, m_pend); end
                n_checks++; if (overflow !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_overflow t %0d: got %b want %b", m_t, overflow, m_ovf); end
                n_checks++; if (idle !== model_idle()) begin n_fail++; $display("[TB] FAIL rand_idle t %0d: got %b want %b", m_t, idle, model_idle()); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_saturate();
        test_clear();
        test_async_reset();
        test_spacing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
